// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges load-use, taken-branch and data-memory-wait stall
// sources into one set of pipeline-register enables and bubble/flush selects.
// Adds a memory-wait timeout with a sticky error and a saturating counter of
// stalled cycles (cycles where the PC is not written).
//
// Control outputs are Mealy (current state plus current inputs).
// dmem handshake: dmem_req_i marks an access in MEM this cycle, dmem_ack_i
// marks its completion in the same cycle; req without ack is a miss that
// freezes the pipeline until ack arrives or the timeout expires.
module pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       if_idrs_i,
  input  logic [4:0]       if_idrt_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic             id_ex_memread_i,
  input  logic             br_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  input  logic             cnt_clr_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_we_o,
  output logic             mem_wb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_to_cnt;
  logic [15:0]      w_to_next;
  logic             r_err;
  logic             w_err_set;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu;
  logic w_mw;
  logic w_pc_we;
  logic w_if_id_we;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_ex_mem_we;
  logic w_mem_wb_bubble;

  // Hazard detection: register 0 never creates a load-use dependency.
  assign w_lu = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                ((if_idrs_i == id_ex_rt_i) || (if_idrt_i == id_ex_rt_i));
  assign w_mw = dmem_req_i && !dmem_ack_i;

  // State register, memory-wait timeout counter and sticky error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= RUN;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_to_cnt <= w_to_next;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Next-state and Mealy control outputs; RUN defaults apply during reset.
  always_comb begin
    w_next          = r_state;
    w_to_next       = r_to_cnt;
    w_err_set       = 1'b0;
    w_pc_we         = 1'b1;
    w_if_id_we      = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_we     = 1'b1;
    w_mem_wb_bubble = 1'b0;
    if (rst_i) begin
      case (r_state)
        RUN, LU_STALL: begin
          if (w_mw) begin
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_ex_mem_we     = 1'b0;
            w_mem_wb_bubble = 1'b1;
            w_next          = MEM_WAIT;
            w_to_next       = 16'd1;
          end else if (w_lu && (r_state == RUN)) begin
            // Branch is not resolved while its operands stall.
            w_pc_we        = 1'b0;
            w_if_id_we     = 1'b0;
            w_id_ex_bubble = 1'b1;
            w_next         = LU_STALL;
          end else begin
            // ID/EX holds a bubble after LU_STALL, so lu is masked there.
            w_if_id_flush = br_taken_i;
            w_next        = RUN;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack_i) begin
            w_if_id_flush = br_taken_i;
            w_next        = RUN;
            w_to_next     = '0;
          end else begin
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_ex_mem_we     = 1'b0;
            w_mem_wb_bubble = 1'b1;
            if (r_to_cnt == TO_LAST) begin
              w_next    = ERR;
              w_err_set = 1'b1;
            end else begin
              w_to_next = r_to_cnt + 16'd1;
            end
          end
        end
        default: begin
          // ERR: pipeline frozen until reset; a late ack is ignored.
          w_pc_we         = 1'b0;
          w_if_id_we      = 1'b0;
          w_ex_mem_we     = 1'b0;
          w_mem_wb_bubble = 1'b1;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_we && (r_state != ERR) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pc_we_o         = w_pc_we;
  assign if_id_we_o      = w_if_id_we;
  assign if_id_flush_o   = w_if_id_flush;
  assign id_ex_bubble_o  = w_id_ex_bubble;
  assign ex_mem_we_o     = w_ex_mem_we;
  assign mem_wb_bubble_o = w_mem_wb_bubble;
  assign err_o           = r_err;
  assign stall_cnt_o     = r_stall_cnt;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: table of single-cycle vectors on a default
// instance, plus hand sequences for memory wait, timeout and saturation.
// Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_bubble,
// ex_mem_we, mem_wb_bubble}.
module tb_pipe_stall_ctrl;

  localparam logic [5:0] C_DEF  = 6'b110010;
  localparam logic [5:0] C_BR   = 6'b111010;
  localparam logic [5:0] C_LU   = 6'b000110;
  localparam logic [5:0] C_MEM  = 6'b000001;

  typedef struct {
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       req;
    logic       ack;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [4:0] rs, rt, ex_rt;
  logic memread, br, req, ack, clr;

  logic pc_a, ifw_a, fl_a, bub_a, exw_a, wbb_a, err_a;
  logic pc_t, ifw_t, fl_t, bub_t, exw_t, wbb_t, err_t;
  logic pc_c, ifw_c, fl_c, bub_c, exw_c, wbb_c, err_c;
  logic [15:0] cnt_a, cnt_t;
  logic [2:0]  cnt_c;
  logic [1:0]  st_a, st_t, st_c;
  logic [5:0]  ctrl_a, ctrl_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[13];

  assign ctrl_a = {pc_a, ifw_a, fl_a, bub_a, exw_a, wbb_a};
  assign ctrl_t = {pc_t, ifw_t, fl_t, bub_t, exw_t, wbb_t};

  pipe_stall_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .if_idrs_i(rs), .if_idrt_i(rt),
    .id_ex_rt_i(ex_rt), .id_ex_memread_i(memread), .br_taken_i(br),
    .dmem_req_i(req), .dmem_ack_i(ack), .cnt_clr_i(clr),
    .pc_we_o(pc_a), .if_id_we_o(ifw_a), .if_id_flush_o(fl_a),
    .id_ex_bubble_o(bub_a), .ex_mem_we_o(exw_a), .mem_wb_bubble_o(wbb_a),
    .err_o(err_a), .stall_cnt_o(cnt_a), .dbg_state_o(st_a)
  );

  pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut_t (
    .clk_i(clk), .rst_i(rst_n), .if_idrs_i(rs), .if_idrt_i(rt),
    .id_ex_rt_i(ex_rt), .id_ex_memread_i(memread), .br_taken_i(br),
    .dmem_req_i(req), .dmem_ack_i(ack), .cnt_clr_i(clr),
    .pc_we_o(pc_t), .if_id_we_o(ifw_t), .if_id_flush_o(fl_t),
    .id_ex_bubble_o(bub_t), .ex_mem_we_o(exw_t), .mem_wb_bubble_o(wbb_t),
    .err_o(err_t), .stall_cnt_o(cnt_t), .dbg_state_o(st_t)
  );

  pipe_stall_ctrl #(.TIMEOUT(64), .CNT_W(3)) dut_c (
    .clk_i(clk), .rst_i(rst_n), .if_idrs_i(rs), .if_idrt_i(rt),
    .id_ex_rt_i(ex_rt), .id_ex_memread_i(memread), .br_taken_i(br),
    .dmem_req_i(req), .dmem_ack_i(ack), .cnt_clr_i(clr),
    .pc_we_o(pc_c), .if_id_we_o(ifw_c), .if_id_flush_o(fl_c),
    .id_ex_bubble_o(bub_c), .ex_mem_we_o(exw_c), .mem_wb_bubble_o(wbb_c),
    .err_o(err_c), .stall_cnt_o(cnt_c), .dbg_state_o(st_c)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic m, input logic [4:0] ert,
                              input logic [4:0] s, input logic [4:0] t,
                              input logic b, input logic rq, input logic ak,
                              input logic [5:0] e);
    vec_t v;
    v.memread = m; v.ex_rt = ert; v.rs = s; v.rt = t;
    v.br = b; v.req = rq; v.ack = ak; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    memread = 1'b0; ex_rt = '0; rs = '0; rt = '0;
    br = 1'b0; req = 1'b0; ack = 1'b0; clr = 1'b0;
  endtask

  // Drive: inputs change at posedge+1, outputs sampled at negedge.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    memread = v.memread; ex_rt = v.ex_rt; rs = v.rs; rt = v.rt;
    br = v.br; req = v.req; ack = v.ack;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector table, applied back to back from reset on dut_a
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, C_DEF); // idle
    tbl[1]  = mk(1, 8, 8, 0, 0, 0, 0, C_LU);  // load-use on rs
    tbl[2]  = mk(1, 8, 8, 0, 0, 0, 0, C_DEF); // LU_STALL masks lu
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, C_DEF); // r0 never hazards
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0, C_BR);  // branch alone
    tbl[5]  = mk(1, 5, 0, 5, 1, 0, 0, C_LU);  // lu on rt wins over branch
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, C_BR);  // branch honoured in LU_STALL
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 1, C_DEF); // req+ack is not a miss
    tbl[8]  = mk(1, 3, 3, 0, 0, 1, 1, C_LU);  // lu with hit access
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, C_MEM); // miss in LU_STALL
    tbl[10] = mk(1, 3, 3, 0, 1, 1, 0, C_MEM); // MEM_WAIT ignores lu/br
    tbl[11] = mk(1, 3, 3, 0, 1, 1, 1, C_BR);  // ack cycle: br honoured
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, C_DEF); // back in RUN

    // Reset state, with a hazard present during reset
    idle();
    rst_n = 1'b0;
    memread = 1'b1; ex_rt = 5'd8; rs = 5'd8; req = 1'b1;
    #12;
    chk("reset_ctrl", 16'(ctrl_a), 16'(C_DEF));
    chk("reset_err", 16'(err_a), 16'd0);
    chk("reset_cnt", cnt_a, 16'd0);
    chk("reset_state", 16'(st_a), 16'd0);
    do_reset();

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), 16'(ctrl_a), 16'(tbl[i].exp));
      next_cycle();
    end
    chk("vec_stall_cnt", cnt_a, 16'd5);

    // Load-use: one stall cycle, then defaults with same inputs
    do_reset();
    memread = 1'b1; ex_rt = 5'd8; rs = 5'd8;
    @(negedge clk);
    chk("lu_ctrl", 16'(ctrl_a), 16'(C_LU));
    next_cycle();
    @(negedge clk);
    chk("lu_next_ctrl", 16'(ctrl_a), 16'(C_DEF));
    next_cycle();
    chk("lu_stall_cnt", cnt_a, 16'd1);

    // Memory wait: 5 miss cycles then ack
    do_reset();
    req = 1'b1; ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mw_wait%0d_ctrl", i), 16'(ctrl_a), 16'(C_MEM));
      next_cycle();
    end
    ack = 1'b1;
    @(negedge clk);
    chk("mw_ack_ctrl", 16'(ctrl_a), 16'(C_DEF));
    next_cycle();
    chk("mw_stall_cnt", cnt_a, 16'd5);
    chk("mw_state_run", 16'(st_a), 16'd0);

    // Timeout on TIMEOUT=4 instance
    do_reset();
    req = 1'b1; ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_ctrl", i), 16'(ctrl_t), 16'(C_MEM));
      next_cycle();
      chk($sformatf("to_err_after%0d", i), 16'(err_t), (i == 4) ? 16'd1 : 16'd0);
    end
    ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("to_late_ack%0d_ctrl", i), 16'(ctrl_t), 16'(C_MEM));
      next_cycle();
      chk($sformatf("to_late_ack%0d_err", i), 16'(err_t), 16'd1);
    end
    chk("to_state_err", 16'(st_t), 16'd3);
    chk("to_stall_cnt", cnt_t, 16'd4);
    rst_n = 1'b0;
    #1;
    chk("to_reset_err", 16'(err_t), 16'd0);
    chk("to_reset_state", 16'(st_t), 16'd0);

    // Counter saturation and clear on CNT_W=3 instance
    do_reset();
    req = 1'b1; ack = 1'b0;
    repeat (3) next_cycle();
    chk("cnt_three", 16'(cnt_c), 16'd3);
    repeat (7) next_cycle();
    chk("cnt_saturated", 16'(cnt_c), 16'd7);
    clr = 1'b1;
    next_cycle();
    chk("cnt_cleared", 16'(cnt_c), 16'd0);
    clr = 1'b0;
    next_cycle();
    chk("cnt_after_clear", 16'(cnt_c), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Merges three stall sources into one consistent set of pipeline-register enables and bubble/flush selects:
  - load-use hazard in ID;
  - taken branch/jump resolved in ID;
  - multi-cycle data-memory access in MEM.
- Adds a memory-wait timeout with a sticky error, and a saturating stall-cycle counter for performance measurement.
- Sits beside the hazard-detection logic. Drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB control.

Parameters:
- TIMEOUT, 64, max consecutive MEM_WAIT cycles without dmem_ack_i before the ERR state; legal range 2..65535.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- if_idrs_i  in  5  rs field of the instruction in IF/ID.
- if_idrt_i  in  5  rt field of the instruction in IF/ID.
- id_ex_rt_i  in  5  destination rt of the instruction in ID/EX.
- id_ex_memread_i  in  1  instruction in ID/EX is a load.
- br_taken_i  in  1  branch or jump taken, resolved in ID this cycle.
- dmem_req_i  in  1  instruction in MEM accesses data memory this cycle.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- cnt_clr_i  in  1  synchronous clear of stall_cnt_o.
- pc_we_o  out  1  PC write enable.
- if_id_we_o  out  1  IF/ID write enable.
- if_id_flush_o  out  1  IF/ID loads a NOP.
- id_ex_bubble_o  out  1  control mux selects zeros into ID/EX.
- ex_mem_we_o  out  1  ID/EX and EX/MEM write enable.
- mem_wb_bubble_o  out  1  MEM/WB loads a NOP.
- err_o  out  1  sticky memory-timeout error.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_we_o=0.

Behaviour:
- Control outputs are Mealy: combinational from the current state plus current inputs. State, timeout counter, err_o and stall_cnt_o are registers.
- Reset (rst_i=0, asynchronous):
  - state=RUN, timeout count=0, err_o=0, stall_cnt_o=0.
  - While in reset, combinational outputs take the RUN defaults below with no hazard.
- Load-use hazard (lu): id_ex_memread_i=1, id_ex_rt_i!=0, and (if_idrs_i==id_ex_rt_i or if_idrt_i==id_ex_rt_i).
- Memory miss (mw): dmem_req_i=1 and dmem_ack_i=0.
- States:
  - RUN, priority mw > lu > br_taken_i:
    - mw: all enables 0, id_ex_bubble_o=0, mem_wb_bubble_o=1, if_id_flush_o=0. Next state MEM_WAIT, timeout count=1.
    - lu: pc_we_o=0, if_id_we_o=0, id_ex_bubble_o=1, ex_mem_we_o=1, if_id_flush_o=0 (a branch is not resolved while its operands stall). Next state LU_STALL.
    - br_taken_i only: pc_we_o=1, if_id_we_o=1, if_id_flush_o=1. Stay in RUN.
    - None of these: pc_we_o=1, if_id_we_o=1, ex_mem_we_o=1, all bubbles and flush 0.
  - LU_STALL: exactly 1 cycle. lu is masked because ID/EX now holds a bubble.
    - mw has priority and is handled as in RUN (next state MEM_WAIT).
    - Otherwise outputs are RUN defaults, br_taken_i is honoured, and next state is RUN.
  - MEM_WAIT: outputs as for mw in RUN; lu and br_taken_i are ignored.
    - dmem_ack_i=1: that cycle uses RUN-default outputs (pipeline advances, br_taken_i honoured, lu ignored). Next state RUN, count=0.
    - No ack and count==TIMEOUT-1: next state ERR, err_o<=1.
    - Otherwise: count increments.
  - ERR: all enables 0, mem_wb_bubble_o=1, err_o=1. Held until reset; ack is ignored.
- Stall counter:
  - Increments when pc_we_o=0 and state!=ERR.
  - Saturates at all-ones with no wrap.
  - cnt_clr_i has priority over increment and clears to 0 in that cycle.
- dmem_req_i and dmem_ack_i both 1 in RUN is treated as no miss; no state change.
- rst_i asserted mid-MEM_WAIT or in ERR returns to RUN, clears err_o, and clears all counts.

Test Plan:
1. Load-use:
   - Stimulus: id_ex_memread_i=1, id_ex_rt_i=8, if_idrs_i=8, one cycle.
   - Required: that cycle pc_we_o=0, if_id_we_o=0, id_ex_bubble_o=1. Next cycle, with inputs unchanged, all RUN defaults. stall_cnt_o=1.
2. Register 0 and branch:
   - Stimulus A: id_ex_rt_i=0 with matching rs and memread=1.
   - Required A: no stall.
   - Stimulus B: br_taken_i=1 alone.
   - Required B: if_id_flush_o=1, pc_we_o=1.
3. Simultaneous:
   - Stimulus: lu and br_taken_i together.
   - Required: flush=0, stall asserted. br_taken_i=1 on the following cycle gives flush=1.
4. Memory wait:
   - Stimulus: dmem_req_i=1, ack low for 5 cycles then high.
   - Required: 5 cycles of all enables 0 and mem_wb_bubble_o=1. Ack cycle outputs RUN defaults. stall_cnt_o=5.
5. Timeout:
   - Stimulus: TIMEOUT=4, dmem_req_i=1, ack never asserted.
   - Required: err_o rises after the 4th wait cycle and stays 1. A late ack has no effect. rst_i=0 clears err_o.
6. Counter:
   - Stimulus: CNT_W=3, continuous stalls.
   - Required: counter saturates at 7. cnt_clr_i=1 gives 0 on the next edge.
